// File: rtl/muldiv_sequencer_pkg.sv
// Shared decode constants for the execute stage: opcode/aluop fields used by
// the decoder and ALU, rstatus exception codes, and the multiply/divide
// sequencer state encoding.
package muldiv_sequencer_pkg;

   localparam logic [4:0]  OP_ALU      = 5'b00000;
   localparam logic [4:0]  ALUOP_MUL   = 5'b00110;
   localparam logic [4:0]  ALUOP_DIV   = 5'b00111;

   localparam logic [31:0] RS_MUL_OVF  = 32'd4;
   localparam logic [31:0] RS_DIV_ZERO = 32'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } md_state_e;

   // True when the DX latch holds a real mul or div instruction.
   function automatic logic is_md_insn(input logic valid, input logic [31:0] ir);
      return valid && (ir[31:27] == OP_ALU) &&
             ((ir[6:2] == ALUOP_MUL) || (ir[6:2] == ALUOP_DIV));
   endfunction

endpackage

// File: rtl/muldiv_sequencer_md_cycle_counter.sv
// md_cycle_counter: CNT_W-bit up-counter with synchronous clear, count enable
// and a terminal-count flag.
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low reset (count -> 0)
//   clr      in   load zero on the next edge (wins over en)
//   en       in   increment on the next edge
//   tc       out  high in the enabled cycle whose increment reaches TERMINAL
module md_cycle_counter
   import muldiv_sequencer_pkg::*;
#(
   parameter int CNT_W    = 7,
   parameter int TERMINAL = 64
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERMINAL);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_inc;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flagging on the incremented value makes the window exactly TERMINAL
   // enabled cycles long, counted from the first cycle after a clear.
   assign tc = en && (cnt_inc == TERM_C);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: execute-stage controller for the iterative multiply/divide
// unit. Spots mul/div in DX, latches operands, pulses the unit start, stalls
// PC/FD/DX until the unit answers (or times out), then presents the result or
// rstatus code to XM for one cycle.
//   clock, reset           clock; asynchronous active-low reset
//   dx_ir/dx_valid         instruction in DX and its valid bit
//   dx_a/dx_b              bypassed operands
//   kill                   DX flush; abandons any operation in flight
//   unit_result/_exception/_ready   multdiv unit response
//   ctrl_mult/ctrl_div     one-cycle start pulses
//   unit_a/unit_b          latched operands to the unit
//   stall                  freeze PC, FD, DX
//   result_valid/result    XM takes result this cycle
//   exc_valid/exc_rstatus  write rstatus code to r30 instead of rd
//   timeout                sticky: the unit never answered
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation; mul/div in DX starts one (stall goes high now)
// BUSY  | unit running; stall high; wait for ready, kill or timeout
// DONE  | one cycle presenting result to XM; stall low
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dx_ir,
   input  logic        dx_valid,
   input  logic [31:0] dx_a,
   input  logic [31:0] dx_b,
   input  logic        kill,
   input  logic [31:0] unit_result,
   input  logic        unit_exception,
   input  logic        unit_ready,
   output logic        ctrl_mult,
   output logic        ctrl_div,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        stall,
   output logic        result_valid,
   output logic [31:0] result,
   output logic        exc_valid,
   output logic [31:0] exc_rstatus,
   output logic        timeout
);

   md_state_e   state_q, state_d;
   logic        ctrl_mult_q, ctrl_mult_d;
   logic        ctrl_div_q, ctrl_div_d;
   logic [31:0] unit_a_q, unit_a_d;
   logic [31:0] unit_b_q, unit_b_d;
   logic        op_div_q, op_div_d;
   logic [31:0] result_q, result_d;
   logic        exc_q, exc_d;
   logic [31:0] exc_rstatus_q, exc_rstatus_d;
   logic        timeout_q, timeout_d;

   logic        is_md;
   logic        dx_is_div;
   logic        cnt_clr;
   logic        cnt_en;
   logic        cnt_tc;
   logic        stall_c;
   logic        result_valid_c;
   logic        exc_valid_c;

   assign is_md     = is_md_insn(dx_valid, dx_ir);
   assign dx_is_div = (dx_ir[6:2] == ALUOP_DIV);
   assign cnt_en    = (state_q == ST_BUSY);

   md_cycle_counter #(
      .CNT_W    (CNT_W),
      .TERMINAL (TIMEOUT_CYCLES)
   ) u_cycle_counter (
      .clock (clock),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tc    (cnt_tc)
   );

   always_comb begin
      state_d        = state_q;
      ctrl_mult_d    = 1'b0;
      ctrl_div_d     = 1'b0;
      unit_a_d       = unit_a_q;
      unit_b_d       = unit_b_q;
      op_div_d       = op_div_q;
      result_d       = result_q;
      exc_d          = exc_q;
      exc_rstatus_d  = exc_rstatus_q;
      timeout_d      = timeout_q;
      cnt_clr        = 1'b0;
      stall_c        = 1'b0;
      result_valid_c = 1'b0;
      exc_valid_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (is_md && !kill) begin
               stall_c     = 1'b1;
               state_d     = ST_BUSY;
               ctrl_mult_d = !dx_is_div;
               ctrl_div_d  = dx_is_div;
               op_div_d    = dx_is_div;
               unit_a_d    = dx_a;
               unit_b_d    = dx_b;
               exc_d       = 1'b0;
               cnt_clr     = 1'b1;
            end
         end

         ST_BUSY: begin
            stall_c = 1'b1;
            if (kill) begin
               state_d = ST_IDLE;
            end else if (unit_ready) begin
               state_d = ST_DONE;
               exc_d   = unit_exception;
               if (unit_exception) begin
                  result_d      = '0;
                  exc_rstatus_d = op_div_q ? RS_DIV_ZERO : RS_MUL_OVF;
               end else begin
                  result_d = unit_result;
               end
            end else if (cnt_tc) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
               result_d  = '0;
               exc_d     = 1'b0;
            end
         end

         ST_DONE: begin
            // DX still holds the finishing instruction here; it must not
            // start again, so is_md is deliberately not looked at.
            result_valid_c = 1'b1;
            exc_valid_c    = exc_q;
            state_d        = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         ctrl_mult_q   <= 1'b0;
         ctrl_div_q    <= 1'b0;
         unit_a_q      <= '0;
         unit_b_q      <= '0;
         op_div_q      <= 1'b0;
         result_q      <= '0;
         exc_q         <= 1'b0;
         exc_rstatus_q <= '0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ctrl_mult_q   <= ctrl_mult_d;
         ctrl_div_q    <= ctrl_div_d;
         unit_a_q      <= unit_a_d;
         unit_b_q      <= unit_b_d;
         op_div_q      <= op_div_d;
         result_q      <= result_d;
         exc_q         <= exc_d;
         exc_rstatus_q <= exc_rstatus_d;
         timeout_q     <= timeout_d;
      end
   end

   // The IDLE stall path is purely combinational from DX, so it is gated by
   // reset to make stall drop the moment reset asserts.
   assign stall        = stall_c && reset;
   assign ctrl_mult    = ctrl_mult_q;
   assign ctrl_div     = ctrl_div_q;
   assign unit_a       = unit_a_q;
   assign unit_b       = unit_b_q;
   assign result_valid = result_valid_c;
   assign result       = result_q;
   assign exc_valid    = exc_valid_c;
   assign exc_rstatus  = exc_rstatus_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

   localparam logic [31:0] I_MUL  = 32'h00C2_2018;  // mul r3,r1,r2
   localparam logic [31:0] I_DIV  = 32'h00C2_201C;  // div r3,r1,r2
   localparam logic [31:0] I_ADD  = 32'h00C2_2000;  // add r3,r1,r2
   localparam logic [31:0] I_ADDI = 32'h28C2_2018;  // non-ALU opcode, mul aluop bits

   logic        clock;
   logic        reset;
   logic [31:0] dx_ir;
   logic        dx_valid;
   logic [31:0] dx_a;
   logic [31:0] dx_b;
   logic        kill;
   logic [31:0] unit_result;
   logic        unit_exception;
   logic        unit_ready;
   logic        ctrl_mult;
   logic        ctrl_div;
   logic [31:0] unit_a;
   logic [31:0] unit_b;
   logic        stall;
   logic        result_valid;
   logic [31:0] result;
   logic        exc_valid;
   logic [31:0] exc_rstatus;
   logic        timeout;

   int errors = 0;
   int checks = 0;
   int n_stall;
   int n_mult;
   int n_div;
   int n_rv;

   muldiv_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
      .clock          (clock),
      .reset          (reset),
      .dx_ir          (dx_ir),
      .dx_valid       (dx_valid),
      .dx_a           (dx_a),
      .dx_b           (dx_b),
      .kill           (kill),
      .unit_result    (unit_result),
      .unit_exception (unit_exception),
      .unit_ready     (unit_ready),
      .ctrl_mult      (ctrl_mult),
      .ctrl_div       (ctrl_div),
      .unit_a         (unit_a),
      .unit_b         (unit_b),
      .stall          (stall),
      .result_valid   (result_valid),
      .result         (result),
      .exc_valid      (exc_valid),
      .exc_rstatus    (exc_rstatus),
      .timeout        (timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
      dx_valid = v;
      dx_ir    = ir;
      dx_a     = a;
      dx_b     = b;
   endtask

   task automatic unit_idle();
      unit_ready     = 1'b0;
      unit_exception = 1'b0;
      unit_result    = 32'h0;
   endtask

   initial begin
      // ---------------- reset state (mul sitting in DX) ----------------
      reset = 1'b0;
      kill  = 1'b0;
      unit_idle();
      drive(1'b1, I_MUL, 32'd6, 32'd7);
      smp();
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_ctrl", {30'b0, ctrl_mult, ctrl_div}, 32'd0);
      chk("rst_unit_a", unit_a, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {29'b0, result_valid, exc_valid, timeout}, 32'd0);
      chk("rst_rstatus", exc_rstatus, 32'd0);
      nxt();
      drive(1'b0, I_ADD, 32'd0, 32'd0);
      reset = 1'b1;
      smp();
      chk("idle_stall", {31'b0, stall}, 32'd0);

      // ---------------- mul, normal: ready on 32nd BUSY cycle ----------------
      nxt();
      drive(1'b1, I_MUL, 32'd6, 32'd7);
      n_stall = 0; n_mult = 0; n_div = 0; n_rv = 0;
      smp();
      chk("mul_c0_stall", {31'b0, stall}, 32'd1);
      chk("mul_c0_ctrl", {31'b0, ctrl_mult}, 32'd0);
      n_stall += int'(stall);
      for (int k = 1; k <= 32; k++) begin
         nxt();
         drive(1'b1, I_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  // DX operands may change; latched copy must not
         unit_ready  = (k == 32);
         unit_result = (k == 32) ? 32'd42 : 32'd0;
         smp();
         n_stall += int'(stall);
         n_mult  += int'(ctrl_mult);
         n_div   += int'(ctrl_div);
         n_rv    += int'(result_valid);
         if (k == 1) chk("mul_pulse_c1", {31'b0, ctrl_mult}, 32'd1);
         if (k == 32) begin
            chk("mul_unit_a", unit_a, 32'd6);
            chk("mul_unit_b", unit_b, 32'd7);
         end
      end
      nxt();
      unit_idle();
      smp();
      chk("mul_stall_cycles", n_stall, 32'd33);
      chk("mul_pulses", n_mult, 32'd1);
      chk("mul_no_div", n_div, 32'd0);
      chk("mul_no_early_rv", n_rv, 32'd0);
      chk("mul_done_stall", {31'b0, stall}, 32'd0);
      chk("mul_done_rv", {31'b0, result_valid}, 32'd1);
      chk("mul_done_result", result, 32'd42);
      chk("mul_done_exc", {31'b0, exc_valid}, 32'd0);
      // the same mul is still in DX during DONE; next cycle must be idle
      nxt();
      drive(1'b1, I_ADD, 32'd0, 32'd0);
      smp();
      chk("mul_no_retrigger", {29'b0, stall, ctrl_mult, result_valid}, 32'd0);

      // ---------------- decode negatives and ready-in-IDLE ----------------
      nxt();
      drive(1'b0, I_MUL, 32'd1, 32'd1);
      smp();
      chk("bubble_mul_stall", {31'b0, stall}, 32'd0);
      nxt();
      drive(1'b1, I_ADDI, 32'd1, 32'd1);
      unit_ready = 1'b1; unit_result = 32'h55;
      smp();
      chk("addi_stall", {31'b0, stall}, 32'd0);
      nxt();
      unit_idle();
      drive(1'b1, I_ADD, 32'd0, 32'd0);
      smp();
      chk("idle_ready_ignored", {30'b0, result_valid, ctrl_mult}, 32'd0);
      chk("idle_ready_result", result, 32'd42);

      // ---------------- div by zero with exception ----------------
      nxt();
      drive(1'b1, I_DIV, 32'd9, 32'd0);
      n_mult = 0; n_div = 0;
      smp();
      chk("div_c0_stall", {31'b0, stall}, 32'd1);
      for (int k = 1; k <= 5; k++) begin
         nxt();
         unit_ready     = (k == 5);
         unit_exception = (k == 5);
         unit_result    = (k == 5) ? 32'hDEAD : 32'd0;
         smp();
         n_mult += int'(ctrl_mult);
         n_div  += int'(ctrl_div);
         if (k == 1) chk("div_pulse_c1", {31'b0, ctrl_div}, 32'd1);
      end
      chk("div_unit_a", unit_a, 32'd9);
      chk("div_unit_b", unit_b, 32'd0);
      nxt();
      unit_idle();
      smp();
      chk("div_pulses", n_div, 32'd1);
      chk("div_no_mult", n_mult, 32'd0);
      chk("div_rv", {31'b0, result_valid}, 32'd1);
      chk("div_exc", {31'b0, exc_valid}, 32'd1);
      chk("div_rstatus", exc_rstatus, 32'd5);
      chk("div_result", result, 32'd0);
      nxt();
      drive(1'b1, I_ADD, 32'd0, 32'd0);
      smp();
      chk("div_after_exc", {30'b0, exc_valid, result_valid}, 32'd0);

      // ---------------- kill mid-op on BUSY cycle 10 ----------------
      nxt();
      drive(1'b1, I_MUL, 32'd3, 32'd3);
      smp();
      for (int k = 1; k <= 10; k++) begin
         nxt();
         kill = (k == 10);
         smp();
      end
      chk("kill_c10_stall", {31'b0, stall}, 32'd1);
      nxt();
      kill = 1'b0;
      drive(1'b0, I_ADD, 32'd0, 32'd0);
      smp();
      chk("kill_next_stall", {31'b0, stall}, 32'd0);
      n_rv = int'(result_valid);
      for (int k = 1; k <= 5; k++) begin
         nxt();
         unit_ready  = (k == 2);
         unit_result = (k == 2) ? 32'd9 : 32'd0;
         smp();
         n_rv += int'(result_valid);
      end
      unit_idle();
      chk("kill_no_rv", n_rv, 32'd0);
      chk("kill_result_kept", result, 32'd0);

      // ---------------- kill and ready collide ----------------
      nxt();
      drive(1'b1, I_MUL, 32'd9, 32'd11);
      smp();
      for (int k = 1; k <= 3; k++) begin
         nxt();
         kill        = (k == 3);
         unit_ready  = (k == 3);
         unit_result = (k == 3) ? 32'd99 : 32'd0;
         smp();
      end
      nxt();
      kill = 1'b0;
      unit_idle();
      drive(1'b0, I_ADD, 32'd0, 32'd0);
      smp();
      chk("coll_rv", {31'b0, result_valid}, 32'd0);
      chk("coll_stall", {31'b0, stall}, 32'd0);
      chk("coll_result", result, 32'd0);
      nxt();
      smp();
      chk("coll_rv_late", {31'b0, result_valid}, 32'd0);

      // ---------------- timeout: no ready ever ----------------
      nxt();
      drive(1'b1, I_MUL, 32'd1, 32'd2);
      n_stall = 0; n_rv = 0;
      smp();
      n_stall += int'(stall);
      for (int k = 1; k <= 64; k++) begin
         nxt();
         smp();
         n_stall += int'(stall);
         n_rv    += int'(result_valid);
         if (k == 64) chk("to_not_yet", {31'b0, timeout}, 32'd0);
      end
      nxt();
      smp();
      chk("to_stall_cycles", n_stall, 32'd65);
      chk("to_no_early_rv", n_rv, 32'd0);
      chk("to_flag", {31'b0, timeout}, 32'd1);
      chk("to_rv", {31'b0, result_valid}, 32'd1);
      chk("to_result", result, 32'd0);
      chk("to_no_exc", {30'b0, exc_valid, stall}, 32'd0);
      nxt();
      drive(1'b1, I_ADD, 32'd0, 32'd0);
      smp();
      nxt();
      smp();
      chk("to_sticky", {30'b0, timeout, result_valid}, 32'd2);

      // ---------------- back-to-back mul, then reset mid-op ----------------
      nxt();
      drive(1'b1, I_MUL, 32'd2, 32'd3);
      smp();
      for (int k = 1; k <= 4; k++) begin
         nxt();
         unit_ready  = (k == 4);
         unit_result = (k == 4) ? 32'd6 : 32'd0;
         smp();
      end
      nxt();
      unit_idle();
      smp();
      chk("b2b_done1", {31'b0, result_valid}, 32'd1);
      chk("b2b_result1", result, 32'd6);
      nxt();
      drive(1'b1, I_MUL, 32'd4, 32'd5);
      smp();
      chk("b2b_start2_stall", {31'b0, stall}, 32'd1);
      chk("b2b_start2_nopulse", {31'b0, ctrl_mult}, 32'd0);
      nxt();
      smp();
      chk("b2b_pulse2", {31'b0, ctrl_mult}, 32'd1);
      chk("b2b_unit_a2", unit_a, 32'd4);
      chk("b2b_unit_b2", unit_b, 32'd5);
      nxt();
      smp();
      chk("b2b_busy_stall", {31'b0, stall}, 32'd1);
      nxt();
      reset = 1'b0;
      #1;
      chk("arst_stall", {31'b0, stall}, 32'd0);
      chk("arst_ops", unit_a | unit_b, 32'd0);
      chk("arst_result", result, 32'd0);
      chk("arst_timeout", {31'b0, timeout}, 32'd0);
      chk("arst_flags", {28'b0, ctrl_mult, ctrl_div, result_valid, exc_valid}, 32'd0);
      drive(1'b0, I_ADD, 32'd0, 32'd0);
      smp();
      nxt();
      reset = 1'b1;
      smp();
      nxt();
      smp();
      chk("post_rst_idle", {29'b0, stall, ctrl_mult, result_valid}, 32'd0);
      nxt();
      drive(1'b1, I_MUL, 32'd8, 32'd8);
      smp();
      chk("post_rst_start", {31'b0, stall}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Execute-stage controller for the iterative multiply/divide unit.
- Detects `mul`/`div` in the DX latch, latches the operands and issues a one-cycle start pulse.
- Holds `stall` high to freeze PC/FD/DX until the unit reports ready, then presents the result (or the rstatus exception value) for exactly one cycle so the instruction advances into XM.
- Sits between the DX pipeline register, the multdiv unit and the XM input mux.

Parameters:
- `TIMEOUT_CYCLES`, 64: max cycles in BUSY before the operation is forcibly aborted with a timeout error.
- `CNT_W`, 7: cycle counter width; must satisfy 2^CNT_W > `TIMEOUT_CYCLES`.

Ports:
- `clock`  in  1  master clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dx_ir`  in  32  instruction in DX latch.
- `dx_valid`  in  1  DX holds a real (non-bubble) instruction.
- `dx_a`  in  32  bypassed operand A.
- `dx_b`  in  32  bypassed operand B.
- `kill`  in  1  flush of DX (taken branch/jump); aborts any op in progress.
- `unit_result`  in  32  multdiv result.
- `unit_exception`  in  1  multdiv overflow / divide-by-zero.
- `unit_ready`  in  1  multdiv result valid (single-cycle pulse).
- `ctrl_mult`  out  1  start-multiply pulse.
- `ctrl_div`  out  1  start-divide pulse.
- `unit_a`  out  32  latched operand A, stable while BUSY.
- `unit_b`  out  32  latched operand B, stable while BUSY.
- `stall`  out  1  freeze PC, FD, DX.
- `result_valid`  out  1  XM must take `result` instead of the ALU output this cycle.
- `result`  out  32  value to write to rd.
- `exc_valid`  out  1  write `exc_rstatus` to r30 instead of rd.
- `exc_rstatus`  out  32  rstatus code.
- `timeout`  out  1  sticky error flag.

Behaviour:
- **Decode**
  - `is_md` = `dx_valid` & opcode `dx_ir[31:27]` == 00000 & aluop `dx_ir[6:2]` ∈ {00110 mul, 00111 div}.
- **States:** IDLE, BUSY, DONE, encoded 2 bits. Reset → IDLE.
- **Reset values:** counter=0, `unit_a`=`unit_b`=0, `result`=0, `exc_rstatus`=0, `timeout`=0; all pulses/flags low.
- **IDLE**
  - If `is_md` & !`kill`: `stall`=1 combinationally in the same cycle.
  - Registered on the edge: `ctrl_mult` or `ctrl_div` high for exactly the next cycle, operands latched, counter cleared → BUSY.
  - `unit_ready` seen in IDLE is ignored.
- **BUSY**
  - `stall`=1; counter increments every cycle.
  - `unit_ready`=1: capture `result`=`unit_result`.
    - If `unit_exception`: `exc_valid`, `exc_rstatus` = 4 (mul) or 5 (div), `result`=0.
    - → DONE.
  - `kill`=1: → IDLE, nothing presented, later `unit_ready` discarded. Kill has priority over simultaneous `unit_ready`.
  - Counter == `TIMEOUT_CYCLES` without ready: `timeout`←1 (sticky until reset), → DONE with `result`=0, no exception.
- **DONE**
  - `stall`=0, `result_valid`=1 (and `exc_valid` if captured) for exactly one cycle → IDLE.
  - Never re-triggers on the instruction still in DX this cycle.
  - Back-to-back `mul`/`div` start one cycle after DONE.
- **Latency:** from `mul`/`div` entering DX to its release = unit latency + 2 cycles.
- `ctrl_mult` and `ctrl_div` are never high together, and never high outside the first BUSY cycle.
- Reset mid-operation: immediate return to IDLE, `stall` drops asynchronously.

Decomposition:
- Shared package (with the decoder/ALU):
  - opcode constants ALU_OP=00000.
  - aluop constants MUL=00110, DIV=00111.
  - rstatus constants RS_MUL_OVF=4, RS_DIV_ZERO=5.
  - state encoding.
- One sub-module: `md_cycle_counter` — CNT_W-bit counter with clear, enable and terminal-count compare.

Test Plan:
- **Mul, normal:** `dx_ir`=mul r3,r1,r2, a=6, b=7; ready after 32 cycles with 42 → `ctrl_mult` pulse in cycle 1 only; `stall` high 33 cycles; DONE gives `result_valid`=1, `result`=42, `exc_valid`=0.
- **Div by zero:** a=9, b=0, `unit_exception`=1 → `exc_valid`=1, `exc_rstatus`=5, `result`=0; `ctrl_div` pulsed, `ctrl_mult` never high.
- **Kill mid-op:** `kill` on BUSY cycle 10, `unit_ready` later → IDLE, `stall` low next cycle, no `result_valid`.
- **Kill/ready collision:** `kill` and `unit_ready` in the same BUSY cycle → kill wins, no `result_valid`.
- **Timeout:** `unit_ready` never asserted → after 64 BUSY cycles `timeout`=1, one `result_valid` with 0; `timeout` stays 1 until reset.
- **Back-to-back + reset:** two consecutive `mul` instructions → two separate start pulses, second one cycle after the first DONE. Assert `reset`=0 during the second BUSY → all outputs 0 asynchronously, IDLE after release.
